// File: rtl/serial_operand_sender.sv
// Serial operand sender: captures an operand pair and shifts it out LSB first,
// framed by a one-cycle comparator clear and a one-cycle done pulse.
// Optional expected-result outputs are enabled by defining SERIAL_SENDER_EXPECT_EN.
module serial_operand_sender #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             ready,
  output logic             a,
  output logic             b,
  output logic             frame,
  output logic             last,
  output logic             clrBar,
  output logic             done,
  output logic             expGt,
  output logic             expEq,
  output logic             expLt
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_b_q;
  logic [CW-1:0]    count_q;
  logic             accept;

  assign accept = start && (state_q == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, regardless of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CLEAR;
      CLEAR:   state_d = SHIFT;
      SHIFT:   if (count_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the state and the shift-register LSBs only, so none of
  // start/opA/opB reaches a pin combinationally.
  always_comb begin
    ready = 1'b0;
    a     = 1'b0;
    b     = 1'b0;
    frame = 1'b0;
    last  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      IDLE:  ready = 1'b1;
      SHIFT: begin
        a     = sh_a_q[0];
        b     = sh_b_q[0];
        frame = 1'b1;
        last  = (count_q == LAST_IDX);
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Held low during reset as well, so the downstream history is cleared then too.
  assign clrBar = ~reset & (state_q != CLEAR);

  // NOTE: the operand shift registers are reset as well, so an aborted
  // transfer leaves no trace of the captured operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      count_q <= '0;
    end else begin
      if (accept) begin
        sh_a_q <= opA;
        sh_b_q <= opB;
      end else if (state_q == SHIFT) begin
        sh_a_q  <= sh_a_q >> 1;
        sh_b_q  <= sh_b_q >> 1;
        count_q <= count_q + CW'(1);
      end
      if (state_q == CLEAR) count_q <= '0;
    end
  end

`ifdef SERIAL_SENDER_EXPECT_EN
  logic exp_gt_q, exp_eq_q, exp_lt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_gt_q <= 1'b0;
      exp_eq_q <= 1'b0;
      exp_lt_q <= 1'b0;
    end else if (accept) begin
      exp_gt_q <= (opA > opB);
      exp_eq_q <= (opA == opB);
      exp_lt_q <= (opA < opB);
    end
  end

  assign expGt = exp_gt_q;
  assign expEq = exp_eq_q;
  assign expLt = exp_lt_q;
`else
  assign expGt = 1'b0;
  assign expEq = 1'b0;
  assign expLt = 1'b0;
`endif

endmodule
